servo_pwm_bank: RTL and testbench

//  Parametrised N-channel hobby-servo PWM generator; next generation of the drive-side servo path.

---
 rtl/servo_pkg.sv | 21 ++
 rtl/servo_pwm_channel.sv | 70 +++++++
 rtl/servo_pwm_bank.sv | 109 ++++++++++
 tb/tb_servo_pwm_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants and helpers for the servo PWM bank: default command width,
// centre position, microsecond-to-cycle conversion and the command-to-width map.
package servo_pkg;

  localparam int CMD_W_DEF = 8;
  localparam int CENTRE    = 1 << (CMD_W_DEF - 1);

  function automatic int unsigned us_to_cycles(input int unsigned us,
                                               input int unsigned clk_hz);
    return us * (clk_hz / 1_000_000);
  endfunction

  // Pulse width in microseconds for an unsigned position command.
  function automatic int unsigned width_us(input int unsigned cmd,
                                           input int unsigned cmd_w,
                                           input int unsigned min_us,
                                           input int unsigned span_us);
    return min_us + ((cmd * span_us) >> cmd_w);
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: target/current position, optional per-frame slew limit
// (macro SERVO_SLEW_EN), width calculation and the registered pwm compare.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int CMD_W     = CMD_W_DEF,
  parameter int MIN_US    = 1000,
  parameter int SPAN_US   = 1000,
  parameter int SLEW_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [31:0]      frame_i,
  input  logic             boundary_i,
  input  logic             load_i,
  input  logic [CMD_W-1:0] load_val_i,
  output logic             pwm_o
);

`ifdef SERVO_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  // Without slew the step exceeds any possible distance, so cur jumps to target.
  localparam int               EFF_STEP = SLEW_EN ? SLEW_STEP : (1 << CMD_W);
  localparam logic [CMD_W:0]   STEP_C   = (CMD_W + 1)'(EFF_STEP);
  localparam logic [CMD_W-1:0] CENTRE_V = CMD_W'(1 << (CMD_W - 1));

  logic [CMD_W-1:0] tgt_q, tgt_d;
  logic [CMD_W-1:0] cur_q, cur_d;
  logic [CMD_W:0]   diff;
  logic [31:0]      width;
  logic             pwm_q, pwm_d;

  always_comb begin
    tgt_d = load_i ? load_val_i : tgt_q;
    cur_d = cur_q;
    diff  = '0;
    if (boundary_i) begin
      if (tgt_d >= cur_q) begin
        diff  = {1'b0, tgt_d - cur_q};
        cur_d = (diff > STEP_C) ? cur_q + STEP_C[CMD_W-1:0] : tgt_d;
      end else begin
        diff  = {1'b0, cur_q - tgt_d};
        cur_d = (diff > STEP_C) ? cur_q - STEP_C[CMD_W-1:0] : tgt_d;
      end
    end
    // Width follows cur, which only moves at a boundary, so a frame never glitches.
    width = width_us(32'(cur_q), CMD_W, MIN_US, SPAN_US);
    pwm_d = enable_i && (frame_i < width);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q <= CENTRE_V;
      cur_q <= CENTRE_V;
      pwm_q <= 1'b0;
    end else begin
      tgt_q <= tgt_d;
      cur_q <= cur_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_pwm_bank.sv
// N-channel frame-aligned servo PWM generator with a one-deep command buffer.
// Define SERVO_SLEW_EN to rate-limit each channel by SLEW_STEP per frame.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int N_CH      = 2,
  parameter int CMD_W     = CMD_W_DEF,
  parameter int FRAME_US  = 20000,
  parameter int MIN_US    = 1000,
  parameter int SPAN_US   = 1000,
  parameter int SLEW_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [N_CH*CMD_W-1:0] cmd,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [N_CH-1:0]       pwm,
  output logic                  frame_tick
);

  localparam int unsigned PRE = us_to_cycles(1, CLK_HZ);
  localparam int          PW  = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int          FW  = $clog2(FRAME_US);

  logic [PW-1:0]         pre_q, pre_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  en_q;
  logic                  tick_q;
  logic                  pend_full_q, pend_full_d;
  logic [N_CH*CMD_W-1:0] pend_q, pend_d;
  logic                  us_tick, wrap, boundary, accept, load;
  logic [31:0]           frame_ext;

  assign us_tick   = enable && (pre_q == PW'(PRE - 1));
  assign wrap      = us_tick && (frame_q == FW'(FRAME_US - 1));
  // The first enabled cycle after enable rises also starts a frame.
  assign boundary  = wrap || (enable && !en_q);
  assign load      = boundary && pend_full_q;
  assign frame_ext = 32'(frame_q);

  // Handshake: cmd_ready is high whenever the single pending slot is empty and
  // reset is released; a command transfers on a cycle with cmd_valid && cmd_ready
  // and is never overwritten -- the next one waits until a boundary frees the slot.
  assign cmd_ready = !rst && !pend_full_q;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    pre_d       = pre_q;
    frame_d     = frame_q;
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    if (!enable) begin
      pre_d   = '0;
      frame_d = '0;
    end else if (us_tick) begin
      pre_d   = '0;
      frame_d = wrap ? '0 : frame_q + FW'(1);
    end else begin
      pre_d   = pre_q + PW'(1);
    end
    if (load) pend_full_d = 1'b0;
    if (accept) begin
      pend_full_d = 1'b1;
      pend_d      = cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q       <= '0;
      frame_q     <= '0;
      en_q        <= 1'b0;
      tick_q      <= 1'b0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      pre_q       <= pre_d;
      frame_q     <= frame_d;
      en_q        <= enable;
      tick_q      <= boundary;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
    end
  end

  assign frame_tick = tick_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    servo_pwm_channel #(
      .CMD_W    (CMD_W),
      .MIN_US   (MIN_US),
      .SPAN_US  (SPAN_US),
      .SLEW_STEP(SLEW_STEP)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .enable_i  (enable),
      .frame_i   (frame_ext),
      .boundary_i(boundary),
      .load_i    (load),
      .load_val_i(pend_q[g*CMD_W +: CMD_W]),
      .pwm_o     (pwm[g])
    );
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: directed command sequence, per-frame pulse widths
// (in clk cycles) checked against hand-computed values through an expected queue.
module tb_servo_pwm_bank;

  localparam int CLK_HZ    = 2_000_000;
  localparam int FRAME_US  = 2200;  // shortened frame keeps the run brief
  localparam int FRAME_CLK = 4400;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  pwm;
  logic        frame_tick;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  int          hi0 = 0, hi1 = 0, period = 0, armed = 0;
  logic        t_acc;
  int          s1, s2;

  servo_pwm_bank #(
    .CLK_HZ  (CLK_HZ),
    .N_CH    (2),
    .CMD_W   (8),
    .FRAME_US(FRAME_US),
    .MIN_US  (1000),
    .SPAN_US (1000),
    .SLEW_STEP(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .pwm       (pwm),
    .frame_tick(frame_tick)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  function automatic logic [31:0] exp_w(input int w0, input int w1);
    return {16'(w1), 16'(w0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // ---------------- monitor: measure each frame's pulses ----------------
  always @(negedge clk) begin
    if (rst || !enable) begin
      armed  = 0;
      hi0    = 0;
      hi1    = 0;
      period = 0;
    end else begin
      if (frame_tick) begin
        if (armed >= 1) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_width: got frame with ch0=%0d ch1=%0d, want no frame queued", hi0, hi1);
          end else begin
            mon_e = exp_q.pop_front();
            check("ch0_width", 32'(hi0), {16'd0, mon_e[15:0]});
            check("ch1_width", 32'(hi1), {16'd0, mon_e[31:16]});
          end
        end
        if (armed >= 2) check("frame_period", 32'(period), 32'(FRAME_CLK));
        armed  = (armed >= 2) ? 2 : armed + 1;
        hi0    = 0;
        hi1    = 0;
        period = 0;
      end
      hi0    = hi0 + int'(pwm[0]);
      hi1    = hi1 + int'(pwm[1]);
      period = period + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    for (int k = 0; k < FRAME_CLK + 20; k++) begin
      @(negedge clk);
      if (frame_tick) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_tick: got no frame_tick in %0d cycles, want one", FRAME_CLK + 20);
  endtask

  task automatic send(input logic [15:0] v, output logic tick_at_accept);
    cmd            = v;
    cmd_valid      = 1'b1;
    tick_at_accept = 1'b0;
    for (int k = 0; k < 2 * FRAME_CLK; k++) begin
      if (cmd_ready) begin
        tick_at_accept = frame_tick;
        @(negedge clk);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    n_vec++;
    n_err++;
    $display("FAIL send: got cmd_ready=0 for %0d cycles, want 1", 2 * FRAME_CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
`ifdef SERVO_SLEW_EN
    s1 = 3030;  // 132
    s2 = 3062;  // 136
`else
    s1 = 3092;  // 140
    s2 = 3092;
`endif
    rst       = 1'b1;
    enable    = 1'b1;
    cmd_valid = 1'b0;
    cmd       = '0;
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;

    // centre pulses from reset
    exp_q.push_back(exp_w(3000, 3000));
    wait_tick();
    check("ready_after_rst", 32'(cmd_ready), 32'd1);
    wait_tick();

    // mid-frame command applies at the next frame
    exp_q.push_back(exp_w(3000, 3000));
    cycles(1000);
    send({8'd0, 8'd255}, t_acc);
    exp_q.push_back(exp_w(3992, 2000));
    wait_tick();

    // back-to-back: second waits for the boundary
    cycles(500);
    send({8'd20, 8'd10}, t_acc);
    check("ready_drop", 32'(cmd_ready), 32'd0);
    exp_q.push_back(exp_w(2078, 2156));
    send({8'd100, 8'd200}, t_acc);
    check("second_on_boundary", 32'(t_acc), 32'd1);
    exp_q.push_back(exp_w(3562, 2780));

    // accept exactly on the boundary cycle
    wait_tick();
    cycles(FRAME_CLK - 1);
    send({8'd192, 8'd64}, t_acc);
    check("accept_was_boundary", 32'(frame_tick), 32'd1);
    check("slot_full_after", 32'(cmd_ready), 32'd0);
    exp_q.push_back(exp_w(3562, 2780));
    exp_q.push_back(exp_w(2500, 3500));
    wait_tick();
    wait_tick();

    // enable dropped mid-pulse
    cycles(1000);
    check("pulse_high_pre_en", 32'(pwm), 32'd3);
    enable = 1'b0;
    @(negedge clk);
    check("en_off_pwm", 32'(pwm), 32'd0);
    check("en_off_tick", 32'(frame_tick), 32'd0);
    cycles(10);
    exp_q.push_back(exp_w(2500, 3500));
    enable = 1'b1;
    wait_tick();
    wait_tick();

    // reset mid-pulse
    cycles(1000);
    check("pulse_high_pre_rst", 32'(pwm), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pwm", 32'(pwm), 32'd0);
    cycles(2);
    rst = 1'b0;
    exp_q.push_back(exp_w(3000, 3000));
    wait_tick();

    // 128 -> 140 on ch0
    cycles(200);
    send({8'd128, 8'd140}, t_acc);
    exp_q.push_back(exp_w(s1, 3000));
    exp_q.push_back(exp_w(s2, 3000));
    exp_q.push_back(exp_w(3092, 3000));
    for (int k = 0; k < 4 * FRAME_CLK && exp_q.size() != 0; k++) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    cycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
